bin2bcd_seq: RTL

Sequential binary-to-BCD converter using the shift-and-add-3 (double dabble) method, one iteration per clock.
- Accepts an unsigned binary value on a start strobe.
- Runs N_BITS add-3/shift iterations over an internal scratch register.
- Presents hundreds/tens/units BCD digits with a one-cycle done pulse.
- Sits between the binary datapath (counters/ALU results) and the BCD/7-segment display stage.

---
 rtl/bin2bcd_seq.sv | 115 +++++++++++
 1 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one add-3/shift iteration per clock.
// Sits between the binary datapath and the BCD / 7-segment display stage.
module bin2bcd_seq #(
   parameter int N_BITS = 8,
   parameter int DIGITS = 3
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [N_BITS-1:0]     i_bin,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [4*DIGITS-1:0]   o_bcd,
   output logic                  o_dbg_state
);

   // Handshake: i_start is a request sampled only while idle (o_busy low); the
   // request is accepted on that edge and i_bin is captured. o_done is a
   // one-cycle strobe marking the edge on which o_bcd took a new value.

   function automatic longint pow10(input int n);
      longint r;
      r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   localparam longint MAX_BCD = pow10(DIGITS) - 1;
   localparam longint MAX_BIN = (longint'(1) << N_BITS) - 1;
   localparam int     SW      = 4*DIGITS + N_BITS;
   localparam int     CNT_W   = (N_BITS > 1) ? $clog2(N_BITS) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N_BITS - 1);

   generate
      if (MAX_BIN > MAX_BCD) begin : g_range_check
         $error("bin2bcd_seq: DIGITS too small to hold 2^N_BITS-1");
      end
   endgenerate

   typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_t;

   state_t              state, state_next;
   logic [SW-1:0]       scratch, scratch_next;
   logic [SW-1:0]       adj, shifted;
   logic [CNT_W-1:0]    cnt, cnt_next;
   logic                busy_next, done_next;
   logic [4*DIGITS-1:0] bcd_next;

   assign o_dbg_state = state;

   // One double-dabble step: correct any digit >= 5 so the shift carries into the next decade.
   always_comb begin
      adj = scratch;
      for (int d = 0; d < DIGITS; d++) begin
         if (scratch[N_BITS + 4*d +: 4] > 4'd4)
            adj[N_BITS + 4*d +: 4] = scratch[N_BITS + 4*d +: 4] + 4'd3;
      end
      shifted = {adj[SW-2:0], 1'b0};
   end

   always_comb begin
      state_next   = state;
      scratch_next = scratch;
      cnt_next     = cnt;
      busy_next    = o_busy;
      done_next    = 1'b0;
      bcd_next     = o_bcd;
      case (state)
         IDLE: begin
            if (i_start) begin
               scratch_next = {{(4*DIGITS){1'b0}}, i_bin};
               cnt_next     = '0;
               busy_next    = 1'b1;
               state_next   = CONV;
            end
         end
         CONV: begin
            scratch_next = shifted;
            if (cnt == LAST) begin
               // Counter returns to zero rather than counting past the last iteration.
               cnt_next   = '0;
               bcd_next   = shifted[SW-1 -: 4*DIGITS];
               done_next  = 1'b1;
               busy_next  = 1'b0;
               state_next = IDLE;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            busy_next  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state   <= IDLE;
         scratch <= '0;
         cnt     <= '0;
         o_busy  <= 1'b0;
         o_done  <= 1'b0;
         o_bcd   <= '0;
      end else begin
         state   <= state_next;
         scratch <= scratch_next;
         cnt     <= cnt_next;
         o_busy  <= busy_next;
         o_done  <= done_next;
         o_bcd   <= bcd_next;
      end
   end

endmodule
